master_slave_jk_ff: RTL and testbench
=====================================

Name: master_slave_jk_ff

Overview:
Master-slave JK flip-flop bank (WIDTH independent bits sharing one clock and one clear).
- Master stage samples the J/K inputs (ports Set/Reset) on the rising clock edge.
- Slave stage transfers the master value to the output on the falling clock edge.
- Both master (Qm) and slave (Qs) states are exported so downstream logic and debug can observe the two-phase hand-off.
- Used as a glitch-free, race-around-free JK storage element in control paths.

Parameters:
- WIDTH, 1, number of independent JK bits; all ports below except clk/clear are WIDTH bits.

Ports:
- clk  input  1  single clock; master acts on rising edge, slave on falling edge.
- clear  input  1  asynchronous, active-low reset (0 = reset asserted).
- Set  input  WIDTH  J input per bit.
- Reset  input  WIDTH  K input per bit.
- Qm  output  WIDTH  master stage state.
- Qs  output  WIDTH  slave stage state; the flip-flop's architectural output Q.

Behaviour:
- Reset:
  - clear=0 immediately (no clock needed) forces Qm=0 and Qs=0 for all bits.
  - Held while clear=0; clock edges are ignored during reset.
  - A clock edge coincident with clear going 0 is ignored.
- Release: clear 0->1 asynchronous. The first rising edge strictly after release is the first master update.
- Master update, rising clk edge, per bit i, using the current slave value Qs[i]:
  - Set=0, Reset=0: Qm[i] <= Qs[i] (hold).
  - Set=0, Reset=1: Qm[i] <= 0.
  - Set=1, Reset=0: Qm[i] <= 1.
  - Set=1, Reset=1: Qm[i] <= ~Qs[i] (toggle).
- Slave update, falling clk edge: Qs <= Qm (all bits).
- Latency:
  - Inputs sampled at rising edge N appear on Qm immediately after that edge.
  - They appear on Qs after the next falling edge, i.e. half a period later.
- No race-around:
  - The master computes only from Qs, which is stable while clk is high.
  - With Set=Reset=1 held, Qs toggles exactly once per full clock period, and Qm leads Qs by half a period.
- Input changes between rising edges have no effect. Only values present at the rising edge matter.
- Outputs are registered. Qm changes only on rising edges or on reset; Qs changes only on falling edges or on reset.
- X/unknown Set/Reset at a rising edge: Qm may become X for that bit. No other bit is affected.
- Bits are fully independent; no cross-bit interaction.
- Reset mid-operation (clear=0 while clk high or low): both stages clear at once. Any pending master value is discarded.

Test Plan:
- Reset: clear=0 with clk toggling (period 2) and Set/Reset random -> Qm=0, Qs=0 throughout; after clear=1 with Set=Reset=0 for 4 cycles -> Qm=Qs=0 (hold).
- Reset path: from Qs=1, set Set=0, Reset=1 -> at next rising edge Qm=0, at following falling edge Qs=0; held 3 cycles -> both stay 0.
- Set path: from Qs=0, set Set=1, Reset=0 -> rising edge Qm=1, falling edge Qs=1; remains 1 while held.
- Toggle: Set=Reset=1 for 12 cycles from Qs=0 -> Qs sequence 1,0,1,0... changes only at falling edges, once per period; Qm is the inverse of Qs while clk high.
- Async clear mid-toggle: assert clear=0 while clk high with Qm=1, Qs=0 -> both 0 immediately, not waiting for an edge; release between edges -> next rising edge resumes toggling from 0.
- WIDTH=4: per-bit J/K = {00,01,10,11} starting from Qs=4'b1111 -> after one full cycle Qs=4'b1010 (bit3 hold=1, bit2 reset=0, bit1 set=1, bit0 toggle=0).

Source files
------------

// File: rtl/master_slave_jk_ff.sv
// Master-slave JK flip-flop bank: master samples J/K on the rising clock edge,
// slave copies the master on the falling edge; both stages are exported.
module master_slave_jk_ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] Set,
  input  logic [WIDTH-1:0] Reset,
  output logic [WIDTH-1:0] Qm,
  output logic [WIDTH-1:0] Qs
);

  logic [WIDTH-1:0] qm_next;

  // JK characteristic equation evaluated against the slave, which is stable while clk is high
  always_comb begin
    qm_next = (Set & ~Qs) | (~Reset & Qs);
  end

  // Master stage: rising edge
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      Qm <= '0;
    end else begin
      Qm <= qm_next;
    end
  end

  // Slave stage: falling edge
  always_ff @(negedge clk or negedge clear) begin
    if (!clear) begin
      Qs <= '0;
    end else begin
      Qs <= Qm;
    end
  end

endmodule

// File: tb/tb_master_slave_jk_ff.sv
// Directed bench for master_slave_jk_ff: reset, set/reset/toggle paths,
// async clear mid-toggle, input changes between edges and per-bit independence.
module tb_master_slave_jk_ff;

  localparam int unsigned W = 4;

  logic         clk;
  logic         clear;
  logic [W-1:0] Set;
  logic [W-1:0] Reset;
  logic [W-1:0] Qm;
  logic [W-1:0] Qs;

  int checks;
  int errors;

  master_slave_jk_ff #(.WIDTH(W)) dut (
    .clk   (clk),
    .clear (clear),
    .Set   (Set),
    .Reset (Reset),
    .Qm    (Qm),
    .Qs    (Qs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic at_rise();
    @(posedge clk);
    #1;
  endtask

  task automatic at_fall();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      Set   = W'($urandom);
      Reset = W'($urandom);
      at_rise();
      checks++;
      if (Qm !== 4'b0000) begin errors++; $display("FAIL reset_qm_rise: Qm=%b expected 0000", Qm); end
      at_fall();
      checks++;
      if (Qs !== 4'b0000) begin errors++; $display("FAIL reset_qs_fall: Qs=%b expected 0000", Qs); end
    end
    Set   = '0;
    Reset = '0;
    clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      at_rise();
      checks++;
      if (Qm !== 4'b0000) begin errors++; $display("FAIL hold_after_release_qm: Qm=%b expected 0000", Qm); end
      at_fall();
      checks++;
      if (Qs !== 4'b0000) begin errors++; $display("FAIL hold_after_release_qs: Qs=%b expected 0000", Qs); end
    end
  endtask

  task automatic test_set();
    Set   = 4'b1111;
    Reset = 4'b0000;
    at_rise();
    checks++;
    if (Qm !== 4'b1111) begin errors++; $display("FAIL set_qm_rise: Qm=%b expected 1111", Qm); end
    checks++;
    if (Qs !== 4'b0000) begin errors++; $display("FAIL set_qs_before_fall: Qs=%b expected 0000", Qs); end
    at_fall();
    checks++;
    if (Qs !== 4'b1111) begin errors++; $display("FAIL set_qs_fall: Qs=%b expected 1111", Qs); end
    for (int i = 0; i < 2; i++) begin
      at_rise();
      at_fall();
      checks++;
      if (Qm !== 4'b1111 || Qs !== 4'b1111) begin
        errors++; $display("FAIL set_hold: Qm=%b Qs=%b expected 1111/1111", Qm, Qs);
      end
    end
  endtask

  task automatic test_reset_path();
    Set   = 4'b0000;
    Reset = 4'b1111;
    at_rise();
    checks++;
    if (Qm !== 4'b0000) begin errors++; $display("FAIL rst_qm_rise: Qm=%b expected 0000", Qm); end
    checks++;
    if (Qs !== 4'b1111) begin errors++; $display("FAIL rst_qs_before_fall: Qs=%b expected 1111", Qs); end
    at_fall();
    checks++;
    if (Qs !== 4'b0000) begin errors++; $display("FAIL rst_qs_fall: Qs=%b expected 0000", Qs); end
    for (int i = 0; i < 3; i++) begin
      at_rise();
      at_fall();
      checks++;
      if (Qm !== 4'b0000 || Qs !== 4'b0000) begin
        errors++; $display("FAIL rst_hold: Qm=%b Qs=%b expected 0000/0000", Qm, Qs);
      end
    end
  endtask

  task automatic test_toggle();
    logic [W-1:0] exp_qs;
    exp_qs = 4'b0000;
    Set    = 4'b1111;
    Reset  = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      at_rise();
      checks++;
      if (Qm !== ~exp_qs || Qs !== exp_qs) begin
        errors++; $display("FAIL toggle_rise[%0d]: Qm=%b Qs=%b expected %b/%b", i, Qm, Qs, ~exp_qs, exp_qs);
      end
      at_fall();
      exp_qs = ~exp_qs;
      checks++;
      if (Qs !== exp_qs) begin
        errors++; $display("FAIL toggle_fall[%0d]: Qs=%b expected %b", i, Qs, exp_qs);
      end
    end
  endtask

  task automatic test_async_clear();
    // Qs is 0 after an even number of toggles
    Set   = 4'b1111;
    Reset = 4'b1111;
    at_rise();
    checks++;
    if (Qm !== 4'b1111 || Qs !== 4'b0000) begin
      errors++; $display("FAIL aclr_pre: Qm=%b Qs=%b expected 1111/0000", Qm, Qs);
    end
    clear = 1'b0;
    #1;
    checks++;
    if (Qm !== 4'b0000 || Qs !== 4'b0000) begin
      errors++; $display("FAIL aclr_immediate: Qm=%b Qs=%b expected 0000/0000", Qm, Qs);
    end
    at_fall();
    checks++;
    if (Qs !== 4'b0000) begin errors++; $display("FAIL aclr_held_fall: Qs=%b expected 0000", Qs); end
    #1;
    clear = 1'b1;
    at_rise();
    checks++;
    if (Qm !== 4'b1111 || Qs !== 4'b0000) begin
      errors++; $display("FAIL aclr_resume_rise: Qm=%b Qs=%b expected 1111/0000", Qm, Qs);
    end
    at_fall();
    checks++;
    if (Qs !== 4'b1111) begin errors++; $display("FAIL aclr_resume_fall: Qs=%b expected 1111", Qs); end
  endtask

  task automatic test_input_ignore();
    // Qs=Qm=1111 here; wiggle inputs away from rising edges
    Set   = 4'b0000;
    Reset = 4'b1111;
    #2;
    Set   = 4'b1111;
    Reset = 4'b0000;
    at_rise();
    checks++;
    if (Qm !== 4'b1111) begin errors++; $display("FAIL ignore_qm_rise: Qm=%b expected 1111", Qm); end
    Set   = 4'b0000;
    Reset = 4'b1111;
    #1;
    checks++;
    if (Qm !== 4'b1111) begin errors++; $display("FAIL ignore_qm_high: Qm=%b expected 1111", Qm); end
    at_fall();
    checks++;
    if (Qs !== 4'b1111) begin errors++; $display("FAIL ignore_qs_fall: Qs=%b expected 1111", Qs); end
  endtask

  task automatic test_width4();
    Set   = 4'b1111;
    Reset = 4'b0000;
    at_rise();
    at_fall();
    checks++;
    if (Qs !== 4'b1111) begin errors++; $display("FAIL w4_preload: Qs=%b expected 1111", Qs); end
    // bit3 hold, bit2 reset, bit1 set, bit0 toggle
    Set   = 4'b0011;
    Reset = 4'b0101;
    at_rise();
    checks++;
    if (Qm !== 4'b1010 || Qs !== 4'b1111) begin
      errors++; $display("FAIL w4_rise: Qm=%b Qs=%b expected 1010/1111", Qm, Qs);
    end
    at_fall();
    checks++;
    if (Qs !== 4'b1010) begin errors++; $display("FAIL w4_fall: Qs=%b expected 1010", Qs); end
    // second cycle: bit0 toggles back, others stay
    at_rise();
    at_fall();
    checks++;
    if (Qm !== 4'b1011 || Qs !== 4'b1011) begin
      errors++; $display("FAIL w4_second: Qm=%b Qs=%b expected 1011/1011", Qm, Qs);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear  = 1'b0;
    Set    = '0;
    Reset  = '0;
    #1;
    checks++;
    if (Qm !== 4'b0000 || Qs !== 4'b0000) begin
      errors++; $display("FAIL reset_initial: Qm=%b Qs=%b expected 0000/0000", Qm, Qs);
    end
    at_fall();
    test_reset();
    test_set();
    test_reset_path();
    test_toggle();
    test_async_clear();
    test_input_ignore();
    test_reset_path();
    test_width4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
